psg_stereo_dac: RTL

PSG_STEREO_DAC -- requirements
Module: psg_stereo_dac

---
 rtl/psg_pkg.sv | 27 ++
 rtl/psg_sd_mod.sv | 25 ++
 rtl/psg_stereo_dac.sv | 121 ++++++++++++
 3 files changed

// File: rtl/psg_pkg.sv
// rtl/psg_pkg.sv - shared stereo-mode enum, widths, LFSR constants and volume scaler for the PSG DAC
package psg_pkg;

  typedef enum logic [1:0] {
    PSG_MONO = 2'd0,
    PSG_ABC  = 2'd1,
    PSG_ACB  = 2'd2
  } psg_stereo_e;

  localparam int          PSG_PCM_W     = 10;
  localparam int          PSG_ACC_W     = 11;
  localparam logic [15:0] PSG_LFSR_SEED = 16'hACE1;
  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] PSG_LFSR_TAPS = 16'hB400;

  function automatic logic [PSG_PCM_W-1:0] psg_scale(
    input logic [PSG_PCM_W-1:0] mix,
    input logic [3:0]           vol
  );
    logic [4:0]           vol_p1;
    logic [PSG_PCM_W+4:0] prod;
    vol_p1 = {1'b0, vol} + 5'd1;
    prod   = {5'b0, mix} * {{PSG_PCM_W{1'b0}}, vol_p1};
    return PSG_PCM_W'(prod >> 4);
  endfunction

endpackage

// File: rtl/psg_sd_mod.sv
// rtl/psg_sd_mod.sv - single-channel first-order sigma-delta modulator
module psg_sd_mod
  import psg_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [PSG_PCM_W-1:0] PCM,
  input  logic                 DITHER,
  output logic                 AUDIO
);

  logic [PSG_ACC_W-1:0] acc;

  // The carry bit is dropped every cycle, so the accumulator wraps instead of saturating
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      acc   <= '0;
      AUDIO <= 1'b0;
    end else begin
      acc   <= {1'b0, acc[PSG_ACC_W-2:0]} + {1'b0, PCM} + {{(PSG_ACC_W-1){1'b0}}, DITHER};
      AUDIO <= acc[PSG_ACC_W-1];
    end
  end

endmodule

// File: rtl/psg_stereo_dac.sv
// rtl/psg_stereo_dac.sv - PSG stereo mixer, volume scaler and dual sigma-delta DAC
// Optional dither LFSR enabled by defining PSG_DAC_DITHER_EN.
module psg_stereo_dac
  import psg_pkg::*;
#(
  parameter logic [3:0] VOL_DEFAULT = 4'd15
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 CE,
  input  logic [7:0]           CHANNEL_A,
  input  logic [7:0]           CHANNEL_B,
  input  logic [7:0]           CHANNEL_C,
  input  logic [1:0]           STEREO,
  input  logic [3:0]           VOL,
  input  logic                 VOL_LD,
  output logic [PSG_PCM_W-1:0] PCM_L,
  output logic [PSG_PCM_W-1:0] PCM_R,
  output logic                 PCM_VALID,
  output logic                 AUDIO_L,
  output logic                 AUDIO_R
);

  logic [7:0]           a_q, b_q, c_q;
  logic [1:0]           mode_q;
  logic                 v1, v2;
  logic [PSG_PCM_W-1:0] mix_l_d, mix_r_d, mix_l_q, mix_r_q;
  logic [PSG_PCM_W-1:0] a_w, b_w, c_w;
  logic [3:0]           vol_q;
  logic                 d_l, d_r;

  assign a_w = {2'b00, a_q};
  assign b_w = {2'b00, b_q};
  assign c_w = {2'b00, c_q};

  // Mode 3 is treated as mono along with mode 0
  always_comb begin
    mix_l_d = a_w + b_w + c_w;
    mix_r_d = a_w + b_w + c_w;
    case (mode_q)
      PSG_ABC: begin
        mix_l_d = (a_w << 1) + b_w;
        mix_r_d = (c_w << 1) + b_w;
      end
      PSG_ACB: begin
        mix_l_d = (a_w << 1) + c_w;
        mix_r_d = (b_w << 1) + c_w;
      end
      default: ;
    endcase
  end

  // Stage 3 reads vol_q before a same-cycle VOL_LD lands, so it sees the old volume
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      mode_q    <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      mix_l_q   <= '0;
      mix_r_q   <= '0;
      PCM_L     <= '0;
      PCM_R     <= '0;
      PCM_VALID <= 1'b0;
      vol_q     <= VOL_DEFAULT;
    end else begin
      if (CE) begin
        a_q    <= CHANNEL_A;
        b_q    <= CHANNEL_B;
        c_q    <= CHANNEL_C;
        mode_q <= STEREO;
      end
      v1 <= CE;
      if (v1) begin
        mix_l_q <= mix_l_d;
        mix_r_q <= mix_r_d;
      end
      v2 <= v1;
      if (v2) begin
        PCM_L <= psg_scale(mix_l_q, vol_q);
        PCM_R <= psg_scale(mix_r_q, vol_q);
      end
      PCM_VALID <= v2;
      if (VOL_LD) vol_q <= VOL;
    end
  end

`ifdef PSG_DAC_DITHER_EN
  logic [15:0] lfsr;

  always_ff @(posedge CLK) begin
    if (!RESET_N) lfsr <= PSG_LFSR_SEED;
    else          lfsr <= {1'b0, lfsr[15:1]} ^ ({16{lfsr[0]}} & PSG_LFSR_TAPS);
  end

  assign d_l = lfsr[0];
  assign d_r = lfsr[8];
`else
  assign d_l = 1'b0;
  assign d_r = 1'b0;
`endif

  psg_sd_mod u_sd_l (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .PCM     (PCM_L),
    .DITHER  (d_l),
    .AUDIO   (AUDIO_L)
  );

  psg_sd_mod u_sd_r (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .PCM     (PCM_R),
    .DITHER  (d_r),
    .AUDIO   (AUDIO_R)
  );

endmodule
